adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 132 +++++++++++++
 tb/tb_adder_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder between two requesters.
// Optional grant counters are enabled by defining ADDER_ARB_STATS_EN.
module adder_arbiter #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [OPW-1:0] req0_a,
    input  logic [OPW-1:0] req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [OPW-1:0] req1_a,
    input  logic [OPW-1:0] req1_b,
    output logic           req1_ready,
    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [7:0]     resp_sum,
    output logic [OPW-1:0] add_a,
    output logic [OPW-1:0] add_b,
`ifdef ADDER_ARB_STATS_EN
    output logic [7:0]     grant_cnt0,
    output logic [7:0]     grant_cnt1,
`endif
    input  logic [7:0]     add_sum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           ptr;
    logic           gnt;
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;
    logic [7:0]     sum_q;

    logic           sel;
    logic           req_acc;
    logic           resp_hs;

    // Pick a requester: a lone valid wins, otherwise the pointer decides.
    always_comb begin
        sel = ptr;
        if (req0_valid && !req1_valid) begin
            sel = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            sel = 1'b1;
        end
    end

    // Request and response handshakes.
    always_comb begin
        req0_ready = rst_n && (state == S_IDLE) && req0_valid && !sel;
        req1_ready = rst_n && (state == S_IDLE) && req1_valid && sel;
        req_acc    = req0_ready || req1_ready;
        resp_hs    = (state == S_RESP) &&
                     (gnt ? resp1_ready : resp0_ready);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (req_acc) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_RESP;
            S_RESP:  if (resp_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture operands on accept, the sum in ISSUE, and move the pointer on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= 1'b0;
            gnt   <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum_q <= '0;
        end else begin
            if (req_acc) begin
                gnt  <= sel;
                op_a <= sel ? req1_a : req0_a;
                op_b <= sel ? req1_b : req0_b;
            end
            if (state == S_ISSUE) begin
                sum_q <= add_sum;
            end
            if (resp_hs) begin
                ptr <= ~gnt;
            end
        end
    end

    // Outputs decoded from the state; everything idles at zero.
    always_comb begin
        add_a       = (state == S_ISSUE) ? op_a : '0;
        add_b       = (state == S_ISSUE) ? op_b : '0;
        resp0_valid = (state == S_RESP) && !gnt;
        resp1_valid = (state == S_RESP) && gnt;
        resp_sum    = (state == S_RESP) ? sum_q : 8'h00;
    end

`ifdef ADDER_ARB_STATS_EN
    // Per-requester accept counters, wrapping at 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= 8'h00;
            grant_cnt1 <= 8'h00;
        end else begin
            if (req0_ready) grant_cnt0 <= grant_cnt0 + 8'h01;
            if (req1_ready) grant_cnt1 <= grant_cnt1 + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a scoreboard of expected responses.
// Define ADDER_ARB_STATS_EN to also exercise the grant counters.
module tb_adder_arbiter;

    localparam int OPW = 4;

    typedef struct {
        bit         idx;
        logic [7:0] sum;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           req0_valid;
    logic [OPW-1:0] req0_a;
    logic [OPW-1:0] req0_b;
    logic           req0_ready;
    logic           req1_valid;
    logic [OPW-1:0] req1_a;
    logic [OPW-1:0] req1_b;
    logic           req1_ready;
    logic           resp0_valid;
    logic           resp0_ready;
    logic           resp1_valid;
    logic           resp1_ready;
    logic [7:0]     resp_sum;
    logic [OPW-1:0] add_a;
    logic [OPW-1:0] add_b;
    logic [7:0]     add_sum;
`ifdef ADDER_ARB_STATS_EN
    logic [7:0]     grant_cnt0;
    logic [7:0]     grant_cnt1;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    // External shared adder model.
    assign add_sum = {4'b0, add_a} + {4'b0, add_b};

    adder_arbiter #(.OPW(OPW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_sum    (resp_sum),
        .add_a       (add_a),
        .add_b       (add_b),
`ifdef ADDER_ARB_STATS_EN
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1),
`endif
        .add_sum     (add_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
        check({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
        check({tag, "_rv0"}, 32'(resp0_valid), 32'd0);
        check({tag, "_rv1"}, 32'(resp1_valid), 32'd0);
        check({tag, "_sum"}, 32'(resp_sum), 32'd0);
        check({tag, "_adda"}, 32'(add_a), 32'd0);
        check({tag, "_addb"}, 32'(add_b), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        sb.delete();
    endtask

    // One full transaction on a single requester with responses always ready.
    task automatic transact(input bit idx, input logic [OPW-1:0] a,
                            input logic [OPW-1:0] b);
        int   n;
        exp_t x;
        if (idx) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        check("acc_rdy0", 32'(req0_ready), 32'(!idx));
        check("acc_rdy1", 32'(req1_ready), 32'(idx));
        sb.push_back('{idx: idx, sum: {4'b0, a} + {4'b0, b}});
        step();
        check("iss_rdy", 32'({req0_ready, req1_ready}), 32'd0);
        check("iss_add_a", 32'(add_a), 32'(a));
        check("iss_add_b", 32'(add_b), 32'(b));
        check("iss_rv", 32'({resp0_valid, resp1_valid}), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!(resp0_valid || resp1_valid) && n < 4) begin
            step();
            n++;
        end
        check("latency", 32'(n), 32'd1);
        x = sb.pop_front();
        check("resp_rv0", 32'(resp0_valid), 32'(!x.idx));
        check("resp_rv1", 32'(resp1_valid), 32'(x.idx));
        check("resp_sum", 32'(resp_sum), 32'(x.sum));
        step();
        check("done_rv", 32'({resp0_valid, resp1_valid}), 32'd0);
        check("done_sum", 32'(resp_sum), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        req0_a      = '0;
        req0_b      = '0;
        req1_a      = '0;
        req1_b      = '0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        #2;
        check_quiet("reset");
        step();
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check_quiet("idle");

        // Single request and maximum operands.
        transact(1'b0, 4'h3, 4'h5);
        transact(1'b1, 4'hF, 4'hF);

        // Contention straight after reset: grants 0,1,0 every 3 cycles.
        do_reset();
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2;
        req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h9;
        #1;
        for (int k = 0; k < 9; k++) begin
            bit g;
            g = bit'((k / 3) % 2);
            if (k % 3 == 0) begin
                check("cont_rdy0", 32'(req0_ready), 32'(!g));
                check("cont_rdy1", 32'(req1_ready), 32'(g));
                sb.push_back('{idx: g,
                               sum: g ? 8'h10 : 8'h03});
            end else begin
                check("cont_busy", 32'({req0_ready, req1_ready}), 32'd0);
            end
            if (k % 3 == 2) begin
                e = sb.pop_front();
                check("cont_rv0", 32'(resp0_valid), 32'(!e.idx));
                check("cont_rv1", 32'(resp1_valid), 32'(e.idx));
                check("cont_sum", 32'(resp_sum), 32'(e.sum));
            end else begin
                check("cont_norv", 32'({resp0_valid, resp1_valid}), 32'd0);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure on response 0 for 5 cycles.
        resp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'h6; req0_b = 4'h7;
        #1;
        check("bp_rdy0", 32'(req0_ready), 32'd1);
        sb.push_back('{idx: 1'b0, sum: 8'h0D});
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h2;
        step();
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("bp_rv0", 32'(resp0_valid), 32'd1);
            check("bp_sum", 32'(resp_sum), 32'(e.sum));
            check("bp_rdy1", 32'(req1_ready), 32'd0);
            step();
        end
        resp0_ready = 1'b1;
        step();
        check("bp_idle_rv0", 32'(resp0_valid), 32'd0);
        check("bp_idle_rdy1", 32'(req1_ready), 32'd1);

        // Requester withdraws before the edge: nothing happens.
        req1_valid = 1'b0;
        #1;
        check("drop_rdy1", 32'(req1_ready), 32'd0);
        step();
        check("drop_adda", 32'(add_a), 32'd0);
        check("drop_rv1", 32'(resp1_valid), 32'd0);
        step();
        check("drop_rv1b", 32'(resp1_valid), 32'd0);

        // Reset while a response is pending.
        resp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 4'h9; req1_b = 4'h4;
        step();
        req1_valid = 1'b0;
        step();
        check("rr_rv1", 32'(resp1_valid), 32'd1);
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1;
        req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h2;
        rst_n = 1'b0;
        #1;
        check_quiet("rr_async");
        #1;
        rst_n = 1'b1;
        sb.delete();
        resp1_ready = 1'b1;
        #1;
        check("rr_norv", 32'({resp0_valid, resp1_valid}), 32'd0);
        check("rr_rdy0", 32'(req0_ready), 32'd1);
        check("rr_rdy1", 32'(req1_ready), 32'd0);
        sb.push_back('{idx: 1'b0, sum: 8'h02});
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        e = sb.pop_front();
        check("rr_rv0", 32'(resp0_valid), 32'(!e.idx));
        check("rr_sum", 32'(resp_sum), 32'(e.sum));
        step();

`ifdef ADDER_ARB_STATS_EN
        do_reset();
        #1;
        check("cnt0_rst", 32'(grant_cnt0), 32'd0);
        for (int i = 0; i < 256; i++) begin
            transact(1'b0, OPW'(i), 4'h1);
            if (i == 254) check("cnt0_255", 32'(grant_cnt0), 32'd255);
        end
        check("cnt0_wrap", 32'(grant_cnt0), 32'd0);
        check("cnt1_zero", 32'(grant_cnt1), 32'd0);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
